// File: rtl/cover_pkg.sv
// cover_pkg: shared constants and the count-width helper for toggle coverage.
package cover_pkg;
  localparam int TOGGLE_WIDTH = 25;
  localparam int COVER_TOTAL  = TOGGLE_WIDTH;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/toggle_cover_detect_if.sv
// toggle_cover_detect_if: monitored signal in, per-bit toggle pulses and coverage status out.
interface toggle_cover_detect_if
  import cover_pkg::*;
#(parameter int WIDTH = TOGGLE_WIDTH);
  logic [WIDTH-1:0]            sig;
  logic                        en;
  logic                        clear;
  logic [WIDTH-1:0]            valid;
  logic [cnt_width(WIDTH)-1:0] covered_cnt;
  logic                        all_covered;
  modport master (output sig, en, clear, input valid, covered_cnt, all_covered);
  modport slave  (input sig, en, clear, output valid, covered_cnt, all_covered);
endinterface

// File: rtl/cover_popcount.sv
// cover_popcount: combinational population count of a WIDTH-bit vector.
module cover_popcount
  import cover_pkg::*;
#(parameter int WIDTH = TOGGLE_WIDTH)(
  input  logic [WIDTH-1:0]            bits,
  output logic [cnt_width(WIDTH)-1:0] count
);
  localparam int CW = cnt_width(WIDTH);
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/toggle_cover_detect.sv
// toggle_cover_detect: per-bit toggle detector with covered mask and count.
// Define TOGGLE_COVER_STICKY_EN to report each bit at most once between clears.
module toggle_cover_detect
  import cover_pkg::*;
#(parameter int WIDTH = COVER_TOTAL)(
  input logic             clock,
  input logic             reset,
  toggle_cover_detect_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  logic [WIDTH-1:0] prev, mask, toggle, mask_base, mask_next, valid_next;
  logic [CW-1:0]    cnt_next;
  logic             primed;
  always_comb begin
    toggle    = (bus.en && primed) ? bus.sig ^ prev : '0;
    mask_base = bus.clear ? '0 : mask;
    mask_next = mask_base | toggle;
`ifdef TOGGLE_COVER_STICKY_EN
    valid_next = toggle & ~mask_base;
`else
    valid_next = toggle;
`endif
  end
  cover_popcount #(.WIDTH(WIDTH)) u_popcount (.bits(mask_next), .count(cnt_next));
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      bus.valid       <= '0;
      bus.covered_cnt <= '0;
      bus.all_covered <= 1'b0;
      prev            <= '0;
      mask            <= '0;
      primed          <= 1'b0;
    end else begin
      bus.valid       <= valid_next;
      bus.covered_cnt <= cnt_next;
      bus.all_covered <= cnt_next == CW'(WIDTH);
      mask            <= mask_next;
      if (bus.en) begin
        prev   <= bus.sig;
        primed <= 1'b1;
      end
    end
endmodule
